// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: edge-detected capture into a circular FWFT FIFO (optional irq via UART_RX_FIFO_IRQ_EN).
// Latency: a byte captured into an empty FIFO is presented on m_data one cycle later.
// Backpressure: the consumer stalls with m_ready; a capture while full is dropped and flagged in overflow.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
`ifdef UART_RX_FIFO_IRQ_EN
    parameter int IRQ_LEVEL = DEPTH / 2,
`endif
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready_clr,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              flush,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clr
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rx_ready_q;
    logic              cap;
    logic              pop;
    logic              push;
    logic              drop;

    // Rising edge of rx_ready: a level held for many cycles is one byte.
    assign cap  = rx_ready & ~rx_ready_q;
    assign pop  = m_valid & m_ready;
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign m_valid = ~empty;
    assign m_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rx_ready_q   <= 1'b0;
            rx_ready_clr <= 1'b0;
        end else begin
            rx_ready_q   <= rx_ready;
            rx_ready_clr <= cap;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (AW + 1)'(1);
                    2'b01:   count <= count - (AW + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Set wins over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= (count >= (AW + 1)'(IRQ_LEVEL)) | overflow;
        end
    end
`endif

endmodule
